clock_frequency_divider: RTL and testbench



---
 rtl/clock_frequency_divider.sv | 40 ++++
 tb/tb_clock_frequency_divider.sv | 92 +++++++++
 2 files changed

// File: rtl/clock_frequency_divider.sv
// Counter plus toggle flop: OutClock has a period of 2*HALF_PERIOD InClock cycles and a 50 % duty cycle.
// Latency: the first rise comes HALF_PERIOD edges after reset release. There is no backpressure; the divider is free-running.
module clock_frequency_divider #(
  parameter int INPUT_FREQUENCY  = 50_000_000,
  parameter int OUTPUT_FREQUENCY = 1
) (
  input  logic InClock,
  input  logic reset,
  output logic OutClock
);

  localparam int HALF_PERIOD   = INPUT_FREQUENCY / (2 * OUTPUT_FREQUENCY);
  localparam int COUNTER_WIDTH = ($clog2(HALF_PERIOD) > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [COUNTER_WIDTH-1:0] TERMINAL_COUNT = COUNTER_WIDTH'(HALF_PERIOD - 1);

  generate
    if (HALF_PERIOD < 1) begin : gIllegalRatio
      $error("clock_frequency_divider: OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
    end
  endgenerate

  // Declaration values match reset so an unreset simulation starts in a known phase.
  logic [COUNTER_WIDTH-1:0] cnt         = '0;
  logic                     outClockReg = 1'b0;

  always_ff @(posedge InClock) begin
    if (reset) begin
      cnt         <= '0;
      outClockReg <= 1'b0;
    end else if (cnt == TERMINAL_COUNT) begin
      cnt         <= '0;
      outClockReg <= ~outClockReg;
    end else begin
      cnt         <= cnt + 1'b1;
    end
  end

  assign OutClock = outClockReg;

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Directed bench for small (/10), minimum (/2), truncating (/12) and production dividers.
module tb_clock_frequency_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic outSmall, outMin, outTrunc, outProd;
  int   passCount = 0;
  int   totalCount = 0;

  always #5 clk = ~clk;

  clock_frequency_divider #(.INPUT_FREQUENCY(20), .OUTPUT_FREQUENCY(2)) dutSmall (
    .InClock(clk), .reset(reset), .OutClock(outSmall));
  clock_frequency_divider #(.INPUT_FREQUENCY(2), .OUTPUT_FREQUENCY(1)) dutMin (
    .InClock(clk), .reset(reset), .OutClock(outMin));
  clock_frequency_divider #(.INPUT_FREQUENCY(25), .OUTPUT_FREQUENCY(2)) dutTrunc (
    .InClock(clk), .reset(reset), .OutClock(outTrunc));
  clock_frequency_divider #(.INPUT_FREQUENCY(50_000_000), .OUTPUT_FREQUENCY(5)) dutProd (
    .InClock(clk), .reset(reset), .OutClock(outProd));

  task automatic check(input string tag, input int observed, input int expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge e counts edges since reset release: small = (e/5)%2, min = e%2, trunc = (e/6)%2.
  task automatic runAndCheck(input string phase, input int firstEdge, input int numEdges);
    for (int e = firstEdge; e < firstEdge + numEdges; e++) begin
      tick();
      check($sformatf("%s small out e=%0d", phase, e), int'(outSmall), (e / 5) % 2);
      check($sformatf("%s small cnt e=%0d", phase, e), int'(dutSmall.cnt), e % 5);
      check($sformatf("%s min out e=%0d", phase, e), int'(outMin), e % 2);
      check($sformatf("%s min cnt e=%0d", phase, e), int'(dutMin.cnt), 0);
      check($sformatf("%s trunc out e=%0d", phase, e), int'(outTrunc), (e / 6) % 2);
    end
  endtask

  task automatic checkResetState(input string phase);
    check({phase, " small out"}, int'(outSmall), 0);
    check({phase, " small cnt"}, int'(dutSmall.cnt), 0);
    check({phase, " min out"}, int'(outMin), 0);
    check({phase, " trunc out"}, int'(outTrunc), 0);
    check({phase, " trunc cnt"}, int'(dutTrunc.cnt), 0);
    check({phase, " prod out"}, int'(outProd), 0);
  endtask

  initial begin
    // Two reset cycles.
    reset = 1'b1;
    tick();
    tick();
    checkResetState("reset");

    // Four small periods, twenty minimum periods, and more than three truncated periods.
    reset = 1'b0;
    runAndCheck("run1", 1, 48);
    check("pre-mid small out", int'(outSmall), 1);
    check("pre-mid small cnt", int'(dutSmall.cnt), 3);

    // Mid-period reset while high with cnt=3.
    reset = 1'b1;
    tick();
    checkResetState("midreset");
    reset = 1'b0;
    runAndCheck("run2", 1, 14);
    check("pre-term small cnt", int'(dutSmall.cnt), 4);
    check("pre-term small out", int'(outSmall), 0);

    // Reset on the terminal-count edge must not toggle; hold it for several cycles.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkResetState($sformatf("termreset%0d", i));
    end

    // Release with no extra latency.
    reset = 1'b0;
    runAndCheck("run3", 1, 30);
    check("prod cnt after run3", int'(dutProd.cnt), 30);
    check("prod out after run3", int'(outProd), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
